// File: rtl/hazard_pkg.sv
// Shared constants for the 5-stage pipeline hazard sequencer: FSM state
// encodings, default register-index width and the hard-wired zero register.
package hazard_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MEMWAIT = 2'd1;
  localparam logic [1:0] ST_REDIR   = 2'd2;

  localparam int DEF_REG_W = 5;

  // $zero is never written, so a load targeting it cannot create a hazard.
  localparam logic [DEF_REG_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a
// load in EX is about to write.
module hazard_lu_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  output logic             lu_o
);

  assign lu_o = ex_mem_read_i
             && (ex_rt_i != REG_W'(ZERO_REG))
             && ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS datapath: load-use stalls, MEM-stage
// redirects and multi-cycle data-memory freezes with timeout.
// Define HAZARD_PERF_CNT_EN to add the stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W  = DEF_REG_W,
  parameter int TO_W   = 8,
  parameter int MEM_TO = 200
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_redirect,
  input  logic             mem_access,
  input  logic             dmem_ack,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             mem_err,
  output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic [1:0]      state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            pend_redir_q, pend_redir_d;
  logic            mem_err_q, mem_err_d;

  // While reset is held the outputs decode as RUN with every input at zero.
  logic [1:0] st_eff;
  logic       ex_load_e, redirect_e, access_e, ack_e;
  logic       lu, mwait, timeout;

  assign st_eff     = RST_N ? state_q : ST_RUN;
  assign ex_load_e  = ex_mem_read  & RST_N;
  assign redirect_e = mem_redirect & RST_N;
  assign access_e   = mem_access   & RST_N;
  assign ack_e      = dmem_ack     & RST_N;
  assign mwait      = access_e & ~ack_e;
  assign timeout    = (wait_cnt_q == TO_W'(MEM_TO));

  hazard_lu_detect #(.REG_W(REG_W)) u_lu_detect (
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rt_i  (id_uses_rt),
    .ex_mem_read_i (ex_load_e),
    .ex_rt_i       (ex_rt),
    .lu_o          (lu)
  );

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path leaves one unassigned (no latches).
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    flush_exmem  = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pend_redir_d = pend_redir_q;
    mem_err_d    = mem_err_q;

    case (st_eff)
      ST_RUN: begin
        if (mwait) begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_we      = 1'b0;
          exmem_we     = 1'b0;
          memwb_bubble = 1'b1;
          pend_redir_d = redirect_e;
          wait_cnt_d   = TO_W'(1);
          state_d      = ST_MEMWAIT;
        end else if (redirect_e) begin
          // Redirect beats a load-use stall: the stalled instruction is flushed anyway.
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          flush_exmem = 1'b1;
        end else if (lu) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
        end
      end

      ST_MEMWAIT: begin
        if (ack_e || timeout) begin
          if (!ack_e) mem_err_d = 1'b1;
          wait_cnt_d = '0;
          state_d    = pend_redir_q ? ST_REDIR : ST_RUN;
        end else begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_we      = 1'b0;
          exmem_we     = 1'b0;
          memwb_bubble = 1'b1;
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end

      ST_REDIR: begin
        flush_ifid   = 1'b1;
        flush_idex   = 1'b1;
        flush_exmem  = 1'b1;
        pend_redir_d = 1'b0;
        state_d      = ST_RUN;
      end

      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_RUN;
      wait_cnt_q   <= '0;
      pend_redir_q <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      pend_redir_q <= pend_redir_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign state_o = state_q;
  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_we && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_ifid && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the pipeline rules.
module tb_hazard_ctrl;

  localparam int REG_W  = 5;
  localparam int MEM_TO = 200;

  // Output vector: {pc,ifid,idex,exmem we, idex_bubble, memwb_bubble, flush ifid,idex,exmem}
  localparam logic [8:0] OUT_RUN    = 9'b1111_00_000;
  localparam logic [8:0] OUT_FREEZE = 9'b0000_01_000;
  localparam logic [8:0] OUT_STALL  = 9'b0011_10_000;
  localparam logic [8:0] OUT_FLUSH  = 9'b1111_00_111;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [REG_W-1:0] id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_mem_read, mem_redirect, mem_access, dmem_ack;
  logic             pc_we, ifid_we, idex_we, exmem_we, idex_bubble, memwb_bubble;
  logic             flush_ifid, flush_idex, flush_exmem, mem_err;
  logic [1:0]       state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0]      stall_cnt, flush_cnt;
`endif
  logic [8:0]       outs;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.REG_W(REG_W), .TO_W(8), .MEM_TO(MEM_TO)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .mem_redirect (mem_redirect),
    .mem_access   (mem_access),
    .dmem_ack     (dmem_ack),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .idex_we      (idex_we),
    .exmem_we     (exmem_we),
    .idex_bubble  (idex_bubble),
    .memwb_bubble (memwb_bubble),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .flush_exmem  (flush_exmem),
    .mem_err      (mem_err),
    .state_o      (state_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  assign outs = {pc_we, ifid_we, idex_we, exmem_we, idex_bubble, memwb_bubble,
                 flush_ifid, flush_idex, flush_exmem};

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    mem_redirect = 1'b0; mem_access = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic random_inputs();
    id_rs = REG_W'($urandom_range(0, 3)); id_rt = REG_W'($urandom_range(0, 3));
    ex_rt = REG_W'($urandom_range(0, 3)); id_uses_rt = 1'($urandom_range(0, 1));
    ex_mem_read  = ($urandom_range(0, 1) == 0);
    mem_redirect = ($urandom_range(0, 5) == 0);
    mem_access   = ($urandom_range(0, 3) == 0);
    dmem_ack     = ($urandom_range(0, 1) == 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    clear_inputs();
    tick();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    random_inputs();
    mem_access = 1'b1; dmem_ack = 1'b0; mem_redirect = 1'b1;
    @(negedge CLK);
    checks++;
    if (outs !== OUT_RUN) begin
      errors++; $display("FAIL reset_outs_in_reset: got %b want %b", outs, OUT_RUN);
    end
    tick();
    @(negedge CLK);
    checks++;
    if (state_o !== 2'd0 || mem_err !== 1'b0 || outs !== OUT_RUN) begin
      errors++; $display("FAIL reset_state: state=%0d err=%b outs=%b want 0 0 %b", state_o, mem_err, outs, OUT_RUN);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters: stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
    end
`endif
    RST_N = 1'b1;
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    @(negedge CLK);
    checks++;
    if (outs !== OUT_STALL) begin
      errors++; $display("FAIL lu_stall: got %b want %b", outs, OUT_STALL);
    end
    tick();
    // The bubble now sits in ID/EX, so the load has moved on.
    ex_mem_read = 1'b0; ex_rt = 5'd0;
    @(negedge CLK);
    checks++;
    if (outs !== OUT_RUN || state_o !== 2'd0) begin
      errors++; $display("FAIL lu_one_cycle: got %b st=%0d want %b st=0", outs, state_o, OUT_RUN);
    end
    tick();
  endtask

  task automatic test_no_stall();
    apply_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    @(negedge CLK);
    checks++;
    if (outs !== OUT_RUN) begin
      errors++; $display("FAIL lu_zero_reg: got %b want %b", outs, OUT_RUN);
    end
    ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
    @(negedge CLK);
    checks++;
    if (outs !== OUT_RUN) begin
      errors++; $display("FAIL lu_rt_unused: got %b want %b", outs, OUT_RUN);
    end
    id_uses_rt = 1'b1;
    #1;
    checks++;
    if (outs !== OUT_STALL) begin
      errors++; $display("FAIL lu_rt_used: got %b want %b", outs, OUT_STALL);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_redirect_lu();
    apply_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; mem_redirect = 1'b1;
    @(negedge CLK);
    checks++;
    if (outs !== OUT_FLUSH) begin
      errors++; $display("FAIL redirect_beats_lu: got %b want %b", outs, OUT_FLUSH);
    end
    tick();
    clear_inputs();
    @(negedge CLK);
    checks++;
    if (state_o !== 2'd0 || outs !== OUT_RUN) begin
      errors++; $display("FAIL redirect_state: st=%0d outs=%b want 0 %b", state_o, outs, OUT_RUN);
    end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    mem_access = 1'b1; dmem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++;
      if (outs !== OUT_FREEZE) begin
        errors++; $display("FAIL mem_freeze_c%0d: got %b want %b", c, outs, OUT_FREEZE);
      end
      tick();
    end
    dmem_ack = 1'b1;
    @(negedge CLK);
    checks++;
    if (outs !== OUT_RUN || state_o !== 2'd1) begin
      errors++; $display("FAIL mem_release: outs=%b st=%0d want %b st=1", outs, state_o, OUT_RUN);
    end
    tick();
    clear_inputs();
    @(negedge CLK);
    checks++;
    if (state_o !== 2'd0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL mem_after: st=%0d err=%b want 0 0", state_o, mem_err);
    end
  endtask

  task automatic test_mem_redirect();
    apply_reset();
    mem_access = 1'b1; mem_redirect = 1'b1; dmem_ack = 1'b0;
    @(negedge CLK);
    checks++;
    if (outs !== OUT_FREEZE) begin
      errors++; $display("FAIL memredir_freeze: got %b want %b", outs, OUT_FREEZE);
    end
    tick();
    // Redirect is captured on entry; dropping it now must not lose it.
    mem_redirect = 1'b0;
    tick();
    dmem_ack = 1'b1;
    @(negedge CLK);
    checks++;
    if (outs !== OUT_RUN || state_o !== 2'd1) begin
      errors++; $display("FAIL memredir_release: outs=%b st=%0d want %b st=1", outs, state_o, OUT_RUN);
    end
    tick();
    clear_inputs();
    ex_mem_read = 1'b1; ex_rt = 5'd6; id_rs = 5'd6;
    @(negedge CLK);
    checks++;
    if (outs !== OUT_FLUSH || state_o !== 2'd2) begin
      errors++; $display("FAIL memredir_redir: outs=%b st=%0d want %b st=2", outs, state_o, OUT_FLUSH);
    end
    tick();
    clear_inputs();
    @(negedge CLK);
    checks++;
    if (outs !== OUT_RUN || state_o !== 2'd0) begin
      errors++; $display("FAIL memredir_back_run: outs=%b st=%0d want %b st=0", outs, state_o, OUT_RUN);
    end
  endtask

  task automatic test_reset_midwait();
    apply_reset();
    mem_access = 1'b1; mem_redirect = 1'b1; dmem_ack = 1'b0;
    tick();
    RST_N = 1'b0;
    @(negedge CLK);
    checks++;
    if (outs !== OUT_RUN) begin
      errors++; $display("FAIL midwait_reset_outs: got %b want %b", outs, OUT_RUN);
    end
    tick();
    RST_N = 1'b1;
    clear_inputs();
    @(negedge CLK);
    checks++;
    if (outs !== OUT_RUN || state_o !== 2'd0) begin
      errors++; $display("FAIL midwait_discard: outs=%b st=%0d want %b st=0", outs, state_o, OUT_RUN);
    end
    tick();
  endtask

  task automatic test_timeout();
    int  frozen;
    bit  released;
    frozen = 0;
    released = 1'b0;
    apply_reset();
    mem_access = 1'b1; dmem_ack = 1'b0;
    for (int i = 0; i < MEM_TO + 50; i++) begin
      @(negedge CLK);
      if (pc_we) begin
        released = 1'b1;
        break;
      end
      frozen++;
      tick();
    end
    checks++;
    if (!released) begin
      errors++; $display("FAIL timeout_release: no release within %0d cycles", MEM_TO + 50);
    end
    checks++;
    if (frozen != MEM_TO) begin
      errors++; $display("FAIL timeout_len: frozen %0d cycles want %0d", frozen, MEM_TO);
    end
    tick();
    clear_inputs();
    @(negedge CLK);
    checks++;
    if (mem_err !== 1'b1 || state_o !== 2'd0) begin
      errors++; $display("FAIL timeout_err: err=%b st=%0d want 1 0", mem_err, state_o);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 16'(MEM_TO) || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL timeout_perf: stall=%0d flush=%0d want %0d 0", stall_cnt, flush_cnt, MEM_TO);
    end
`endif
    for (int i = 0; i < 3; i++) tick();
    @(negedge CLK);
    checks++;
    if (mem_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: err=%b want 1", mem_err);
    end
    RST_N = 1'b0;
    tick();
    @(negedge CLK);
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL timeout_err_clear: err=%b want 0", mem_err);
    end
    RST_N = 1'b1;
    tick();
  endtask

  // Behavioural model: a memory wait lasts until ack or MEM_TO cycles have
  // been spent frozen; a redirect seen when the wait began replays afterwards.
  task automatic test_random();
    bit         waiting, pend, redir_now, err, lu, done;
    int         waited, stalls, flushes;
    logic [8:0] exp;
    logic [1:0] exp_st;
    waiting = 0; pend = 0; redir_now = 0; err = 0; waited = 0; stalls = 0; flushes = 0;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      random_inputs();
      RST_N = ($urandom_range(0, 63) != 0);
      lu = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
      done = waiting && (dmem_ack || waited == MEM_TO);
      exp_st = redir_now ? 2'd2 : (waiting ? 2'd1 : 2'd0);
      if (!RST_N)                            exp = OUT_RUN;
      else if (redir_now)                    exp = OUT_FLUSH;
      else if (waiting)                      exp = done ? OUT_RUN : OUT_FREEZE;
      else if (mem_access && !dmem_ack)      exp = OUT_FREEZE;
      else if (mem_redirect)                 exp = OUT_FLUSH;
      else if (lu)                           exp = OUT_STALL;
      else                                   exp = OUT_RUN;
      @(negedge CLK);
      checks++;
      if (outs !== exp || state_o !== exp_st || mem_err !== err) begin
        errors++;
        $display("FAIL rand_c%0d: outs=%b st=%0d err=%b want %b st=%0d err=%b",
                 cyc, outs, state_o, mem_err, exp, exp_st, err);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_cnt !== 16'(stalls) || flush_cnt !== 16'(flushes)) begin
        errors++;
        $display("FAIL rand_perf_c%0d: stall=%0d flush=%0d want %0d %0d",
                 cyc, stall_cnt, flush_cnt, stalls, flushes);
      end
`endif
      if (!RST_N) begin
        waiting = 0; pend = 0; redir_now = 0; err = 0; waited = 0; stalls = 0; flushes = 0;
      end else begin
        if (!exp[8]) stalls++;
        if (exp[2])  flushes++;
        if (redir_now) begin
          redir_now = 0;
        end else if (waiting) begin
          if (done) begin
            if (!dmem_ack) err = 1;
            waiting = 0; redir_now = pend; pend = 0;
          end else begin
            waited++;
          end
        end else if (mem_access && !dmem_ack) begin
          waiting = 1; waited = 1; pend = mem_redirect;
        end
      end
      tick();
    end
    clear_inputs();
    RST_N = 1'b1;
  endtask

  initial begin
    clear_inputs();
    RST_N = 1'b0;
    #1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_redirect_lu();
    test_mem_wait();
    test_mem_redirect();
    test_reset_midwait();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
